// File: rtl/int_regfile_mp.sv
// int_regfile_mp: parametrised NUM_REGS x XLEN register file with post-reset clear, optional bypass and `INT_REGFILE_SCOREBOARD_EN pending scoreboard
module int_regfile_mp #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int WR_BYPASS    = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0] rs_data,
  input  logic [AW-1:0]                rd_addr,
  input  logic [XLEN-1:0]              rd_data,
  input  logic                         rd_en,
`ifdef INT_REGFILE_SCOREBOARD_EN
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  output logic [NUM_RD_PORTS-1:0]      rs_pending,
`endif
  output logic                         ready
);
  typedef enum logic {INIT, READY} state_t;
  state_t          r_state;
  logic [AW-1:0]   r_clr_idx;
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_ready;
  logic            w_wr;
  assign w_ready = (r_state == READY) && !rst;
  assign w_wr    = rd_en && (rd_addr != '0);
  assign ready   = w_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= INIT;
      r_clr_idx <= AW'(1);
    end else if (r_state == INIT) begin
      r_regs[r_clr_idx] <= '0;
      r_clr_idx         <= r_clr_idx + AW'(1);
      if (r_clr_idx == AW'(NUM_REGS-1)) r_state <= READY;
    end else if (w_wr) begin
      r_regs[rd_addr] <= rd_data;
    end
  end
`ifdef INT_REGFILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  // set is applied after clear so a new producer supersedes the retiring one
  assign w_clr_mask = w_wr ? (NUM_REGS'(1) << rd_addr) : '0;
  assign w_set_mask = (issue_en && issue_addr != '0) ? (NUM_REGS'(1) << issue_addr) : '0;
  always_ff @(posedge clk) begin
    r_pending <= (rst || r_state == INIT) ? '0 : (((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1));
  end
`endif
  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_byp;
    assign w_a   = rs_addr[i*AW +: AW];
    assign w_byp = (WR_BYPASS != 0) && rd_en && (rd_addr == w_a);
    assign rs_data[i*XLEN +: XLEN] = (!w_ready || w_a == '0) ? '0 : w_byp ? rd_data : r_regs[w_a];
`ifdef INT_REGFILE_SCOREBOARD_EN
    assign rs_pending[i] = w_ready && !w_byp && r_pending[w_a];
`endif
  end
endmodule

// File: tb/tb_int_regfile_mp.sv
// tb_int_regfile_mp: directed bench for int_regfile_mp (default, no-bypass and 64-bit/4-port/16-reg builds)
module tb_int_regfile_mp;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [9:0]   rs_addr = '0;
  logic [63:0]  rs_data, rs_data_nb;
  logic [4:0]   rd_addr = '0;
  logic [31:0]  rd_data = '0;
  logic         rd_en = 0;
  logic         ready, ready_nb;
  logic [15:0]  rs_addr2 = '0;
  logic [255:0] rs_data2;
  logic [3:0]   rd_addr2 = '0;
  logic [63:0]  rd_data2 = '0;
  logic         rd_en2 = 0;
  logic         ready2;
`ifdef INT_REGFILE_SCOREBOARD_EN
  logic         issue_en = 0;
  logic [4:0]   issue_addr = '0;
  logic [1:0]   pend, pend_nb;
  logic [3:0]   pend2;
`endif
  int checks = 0;
  int errors = 0;
  int cnt;
  int e2;

  int_regfile_mp u0 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_en(rd_en),
`ifdef INT_REGFILE_SCOREBOARD_EN
    .issue_en(issue_en), .issue_addr(issue_addr), .rs_pending(pend),
`endif
    .ready(ready));

  int_regfile_mp #(.WR_BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_en(rd_en),
`ifdef INT_REGFILE_SCOREBOARD_EN
    .issue_en(issue_en), .issue_addr(issue_addr), .rs_pending(pend_nb),
`endif
    .ready(ready_nb));

  int_regfile_mp #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(4)) u2 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr2), .rs_data(rs_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_en(rd_en2),
`ifdef INT_REGFILE_SCOREBOARD_EN
    .issue_en(1'b0), .issue_addr(4'd0), .rs_pending(pend2),
`endif
    .ready(ready2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("ready_in_rst", {63'd0, ready}, 64'd0);
    chk("ready2_in_rst", {63'd0, ready2}, 64'd0);
    chk("rd_in_rst", rs_data, 64'd0);
    rst = 0;
    cnt = 0;
    e2 = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
      if (ready2 && e2 == 0) e2 = cnt;
    end
    chk("init_edges", 64'(cnt), 64'd31);
    chk("init_edges_16", 64'(e2), 64'd15);
    chk("ready_nb", {63'd0, ready_nb}, 64'd1);
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(31 - a), 5'(a)};
      #1 chk("zero_sweep", rs_data, 64'd0);
    end
    // write x5 then read it back with x0 on port 1
    tick();
    rs_addr = {5'd0, 5'd1};
    rd_en = 1; rd_addr = 5; rd_data = 32'hDEADBEEF;
    tick();
    rd_en = 0;
    rs_addr = {5'd0, 5'd5};
    #1 chk("x5_read", rs_data, 64'h00000000_DEADBEEF);
    chk("x5_read_nb", rs_data_nb, 64'h00000000_DEADBEEF);
    rs_addr = {5'd5, 5'd0};
    rd_en = 1; rd_addr = 0; rd_data = 32'h1234;
    #1 chk("x0_write_same", rs_data, 64'hDEADBEEF_00000000);
    tick();
    rd_en = 0;
    #1 chk("x0_write_after", rs_data, 64'hDEADBEEF_00000000);
    // bypass vs. old value on x7, both ports addressing it
    rs_addr = {5'd7, 5'd7};
    rd_en = 1; rd_addr = 7; rd_data = 32'hA5A5A5A5;
    #1 chk("bypass", rs_data, 64'hA5A5A5A5_A5A5A5A5);
    chk("no_bypass_old", rs_data_nb, 64'd0);
    tick();
    rd_en = 0;
    #1 chk("x7_after", rs_data, 64'hA5A5A5A5_A5A5A5A5);
    chk("x7_after_nb", rs_data_nb, 64'hA5A5A5A5_A5A5A5A5);
    // wide variant: all four ports on x15
    rs_addr2 = {4{4'd15}};
    rd_en2 = 1; rd_addr2 = 15; rd_data2 = 64'hFFFF_0000_1234_5678;
    tick();
    rd_en2 = 0; rd_data2 = '0;
    #1 for (int p = 0; p < 4; p++) chk("x15_wide", rs_data2[p*64 +: 64], 64'hFFFF_0000_1234_5678);
    rs_addr2 = {4'd15, 4'd0, 4'd15, 4'd0};
    #1 chk("x15_wide_mix", rs_data2[127:0], {64'hFFFF_0000_1234_5678, 64'd0});
`ifdef INT_REGFILE_SCOREBOARD_EN
    rs_addr = {5'd0, 5'd3};
    issue_en = 1; issue_addr = 3;
    #1 chk("pend_before", {62'd0, pend}, 64'd0);
    tick();
    issue_en = 0;
    #1 chk("pend_issued", {62'd0, pend}, 64'd1);
    rd_en = 1; rd_addr = 3; rd_data = 32'h33; issue_en = 1; issue_addr = 3;
    #1 chk("pend_bypass_mask", {62'd0, pend}, 64'd0);
    chk("pend_no_bypass", {62'd0, pend_nb}, 64'd1);
    tick();
    rd_en = 0; issue_en = 0;
    #1 chk("pend_set_wins", {62'd0, pend}, 64'd1);
    chk("pend_set_wins_nb", {62'd0, pend_nb}, 64'd1);
    rd_en = 1; rd_addr = 3; rd_data = 32'h44;
    tick();
    rd_en = 0;
    #1 chk("pend_cleared", {62'd0, pend}, 64'd0);
    chk("x3_data", rs_data, 64'h44);
    issue_en = 1; issue_addr = 0;
    rs_addr = {5'd0, 5'd0};
    tick();
    issue_en = 0;
    #1 chk("pend_x0", {62'd0, pend}, 64'd0);
`endif
    // reset mid-INIT restarts the clear; writes during INIT are dropped
    rst = 1;
    rs_addr = {5'd7, 5'd5};
    #1 chk("rd_gated_rst", rs_data, 64'd0);
    chk("ready_drop", {63'd0, ready}, 64'd0);
    tick();
    rst = 0;
    repeat (10) tick();
    rd_en = 1; rd_addr = 20; rd_data = 32'hFFFF;
    rs_addr = {5'd20, 5'd25};
    #1 chk("rd_in_init", rs_data, 64'd0);
    chk("ready_in_init", {63'd0, ready}, 64'd0);
    rst = 1;
    tick();
    rst = 0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      rd_en = cnt[0];
      rd_addr = 5'(20 + (cnt % 8));
      tick();
      cnt++;
    end
    rd_en = 0;
    chk("restart_edges", 64'(cnt), 64'd31);
`ifdef INT_REGFILE_SCOREBOARD_EN
    rs_addr = {5'd0, 5'd3};
    #1 chk("pend_after_rst", {62'd0, pend}, 64'd0);
`endif
    for (int a = 20; a < 28; a += 2) begin
      rs_addr = {5'(a + 1), 5'(a)};
      #1 chk("init_write_dropped", rs_data, 64'd0);
    end
    rs_addr = {5'd7, 5'd5};
    #1 chk("cleared_after_restart", rs_data, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
